// File: rtl/score_pkg.sv
// Shared definitions for the BCD score display: game-state encodings,
// seven-segment patterns and the digit-to-segment decoder.
package score_pkg;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RUN      = 2'd1,
    ST_CLEAR    = 2'd2,
    ST_HOLD_ALT = 2'd3
  } st_e;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_score_display_if.sv
// Control and display bundle between the game FSM (master) and the score
// display block (slave).
interface bcd_score_display_if #(
  parameter int DIGITS = 4
);
  logic [1:0]          st;
  logic                dir;
  logic                show_best;
  logic [4*DIGITS-1:0] score_bcd;
  logic [4*DIGITS-1:0] best_bcd;
  logic                ovf;
  logic [7*DIGITS-1:0] hex;

  modport master (
    output st, dir, show_best,
    input  score_bcd, best_bcd, ovf, hex
  );

  modport slave (
    input  st, dir, show_best,
    output score_bcd, best_bcd, ovf, hex
  );
endinterface

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the up/down score counter. cout flags that this digit
// would roll over (9 going up, 0 going down) when its carry-in is set.
module bcd_digit_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (en && cin) begin
      // Out-of-range values are steered back into 0..9 on the next step
      if (!dir) begin
        q_d = (q_q >= 4'd9) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0 || q_q > 4'd9) ? 4'd9 : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign cout = cin && (dir ? (q_q == 4'd0) : (q_q == 4'd9));

endmodule

// File: rtl/bcd_score_display.sv
// Score counter top: tick prescaler, BCD digit chain with saturate/wrap,
// best-score capture on CLEAR, leading-zero blanking and registered HEX drive.
module bcd_score_display
  import score_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TICK_DIV       = 5_000_000,
  parameter bit SATURATE       = 1'b1,
  parameter bit BLANK_LZ       = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  bcd_score_display_if.slave bus
);
  localparam int                  PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]       PSC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7*DIGITS-1:0] HEX_OFF  = {(7*DIGITS){SEG_ACTIVE_LOW}};

  st_e                 st_w;
  logic                run_w, clr_w, tick_w;
  logic [PW-1:0]       psc_q, psc_d;
  logic [4*DIGITS-1:0] score_w, best_q, best_d, sel_w;
  logic [DIGITS-1:0]   cin_w, cout_w, lz_w;
  logic                digit_en_w, ovf_evt_w, ovf_q, ovf_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;

  assign st_w   = st_e'(bus.st);
  assign run_w  = (st_w == ST_RUN);
  assign clr_w  = (st_w == ST_CLEAR);
  assign tick_w = run_w && (psc_q == PSC_LAST);

  always_comb begin
    psc_d = psc_q;
    if (clr_w) begin
      psc_d = '0;
    end else if (run_w) begin
      psc_d = tick_w ? '0 : psc_q + 1'b1;
    end
  end

  // Carry-in per digit is derived from the registered digits (look-ahead),
  // so the chain never loops back through the digit outputs.
  always_comb begin
    logic chain;
    chain = tick_w;
    for (int k = 0; k < DIGITS; k++) begin
      cin_w[k] = chain;
      chain = chain && (bus.dir ? (score_w[4*k +: 4] == 4'd0)
                                : (score_w[4*k +: 4] == 4'd9));
    end
  end

  // The whole value rolls over only when every digit does
  assign ovf_evt_w  = &cout_w;
  assign digit_en_w = !(SATURATE && ovf_evt_w);

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_cnt u_digit (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_w),
        .en   (digit_en_w),
        .dir  (bus.dir),
        .cin  (cin_w[gi]),
        .q    (score_w[4*gi +: 4]),
        .cout (cout_w[gi])
      );
    end
  endgenerate

  // Unsigned compare of packed BCD is an MSD-first digit-wise compare
  always_comb begin
    best_d = best_q;
    if (clr_w && (score_w > best_q)) begin
      best_d = score_w;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clr_w) begin
      ovf_d = 1'b0;
    end else if (ovf_evt_w) begin
      ovf_d = 1'b1;
    end
  end

  assign sel_w = bus.show_best ? best_q : score_w;

  always_comb begin
    logic zero;
    zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero    = zero && (sel_w[4*k +: 4] == 4'd0);
      lz_w[k] = zero;
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      logic [6:0] seg;
      assign seg = (BLANK_LZ && (gi > 0) && lz_w[gi]) ? SEG_BLANK
                                                      : seg7(sel_w[4*gi +: 4]);
      assign hex_d[7*gi +: 7] = SEG_ACTIVE_LOW ? ~seg : seg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q  <= '0;
      best_q <= '0;
      ovf_q  <= 1'b0;
      hex_q  <= HEX_OFF;
    end else begin
      psc_q  <= psc_d;
      best_q <= best_d;
      ovf_q  <= ovf_d;
      hex_q  <= hex_d;
    end
  end

  assign bus.score_bcd = score_w;
  assign bus.best_bcd  = best_q;
  assign bus.ovf       = ovf_q;
  assign bus.hex       = hex_q;

endmodule

// File: tb/tb_bcd_score_display.sv
// Two score displays (saturating / wrapping + leading-zero blanking) driven
// in lockstep and compared every cycle against an integer reference model.
module tb_bcd_score_display;
  localparam int D    = 4;
  localparam int TD   = 4;
  localparam int MAXV = 9999;
  localparam logic [27:0] HEX_OFF = 28'hFFF_FFFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] st;
  logic       dir;
  logic       sb;

  always #5 clk = ~clk;

  bcd_score_display_if #(.DIGITS(D)) if_a ();
  bcd_score_display_if #(.DIGITS(D)) if_b ();

  assign if_a.st = st;  assign if_a.dir = dir;  assign if_a.show_best = sb;
  assign if_b.st = st;  assign if_b.dir = dir;  assign if_b.show_best = sb;

  bcd_score_display #(.DIGITS(D), .TICK_DIV(TD), .SATURATE(1'b1),
                      .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

  bcd_score_display #(.DIGITS(D), .TICK_DIV(TD), .SATURATE(1'b0),
                      .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  typedef struct packed {
    logic [15:0] s;
    logic [15:0] b;
    logic        o;
    logic [27:0] h;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int          m_score[2];
  int          m_best[2];
  int          m_psc;
  bit          m_ovf[2];
  logic [27:0] m_hex[2];
  bit          m_sat[2] = '{1'b1, 1'b0};
  bit          m_blz[2] = '{1'b0, 1'b1};
  int          segtab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  int errors = 0;
  int checks = 0;
  int phase_no = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    p = v;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] hex_of(input int v, input bit blz);
    logic [27:0] r;
    int p, dg, seg;
    p = 1;
    for (int k = 0; k < D; k++) begin
      dg  = (v / p) % 10;
      seg = (blz && k > 0 && v < p) ? 0 : segtab[dg];
      r[7*k +: 7] = ~7'(seg);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_psc = 0;
    for (int i = 0; i < 2; i++) begin
      m_score[i] = 0;
      m_best[i]  = 0;
      m_ovf[i]   = 1'b0;
      m_hex[i]   = HEX_OFF;
    end
  endtask

  task automatic model_edge();
    bit t;
    t = (st == 2'd1) && (m_psc == TD - 1);
    for (int i = 0; i < 2; i++) begin
      m_hex[i] = hex_of(sb ? m_best[i] : m_score[i], m_blz[i]);
      if (st == 2'd2) begin
        if (m_score[i] > m_best[i]) m_best[i] = m_score[i];
        m_score[i] = 0;
        m_ovf[i]   = 1'b0;
      end else if (t) begin
        if (!dir) begin
          if (m_score[i] == MAXV) begin
            m_ovf[i]   = 1'b1;
            m_score[i] = m_sat[i] ? MAXV : 0;
          end else begin
            m_score[i]++;
          end
        end else begin
          if (m_score[i] == 0) begin
            m_ovf[i]   = 1'b1;
            m_score[i] = m_sat[i] ? 0 : MAXV;
          end else begin
            m_score[i]--;
          end
        end
      end
    end
    if (st == 2'd2) m_psc = 0;
    else if (st == 2'd1) m_psc = t ? 0 : m_psc + 1;
  endtask

  task automatic push_exp();
    qa.push_back(exp_t'{to_bcd(m_score[0]), to_bcd(m_best[0]), m_ovf[0], m_hex[0]});
    qb.push_back(exp_t'{to_bcd(m_score[1]), to_bcd(m_best[1]), m_ovf[1], m_hex[1]});
  endtask

  task automatic step(input logic [1:0] s, input logic d, input logic b);
    st = s; dir = d; sb = b;
    @(posedge clk);
    model_edge();
    push_exp();
    @(negedge clk);
  endtask

  task automatic phase(input logic [1:0] s, input logic d, input logic b, input int n);
    phase_no++;
    $display("phase %0d: st=%0d dir=%0d show_best=%0d cycles=%0d", phase_no, s, d, b, n);
    for (int c = 0; c < n; c++) step(s, d, b);
  endtask

  // Reset lands between a rising and a falling edge, so the check at the
  // falling edge sees the effect before any further clock edge.
  task automatic pulse_reset(input logic [1:0] s, input logic d, input logic b);
    phase_no++;
    $display("phase %0d: reset pulse during st=%0d", phase_no, s);
    st = s; dir = d; sb = b;
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    model_reset();
    push_exp();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic rand_phases(input int n);
    logic [1:0] s;
    logic d, b;
    int len;
    for (int p = 0; p < n; p++) begin
      s   = 2'($urandom_range(0, 3));
      d   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      len = (s == 2'd2) ? $urandom_range(1, 2) : $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) pulse_reset(2'd1, d, b);
      else phase(s, d, b, len);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a.score", 32'(if_a.score_bcd), 32'(ea.s));
      chk("a.best",  32'(if_a.best_bcd),  32'(ea.b));
      chk("a.ovf",   32'(if_a.ovf),       32'(ea.o));
      chk("a.hex",   32'(if_a.hex),       32'(ea.h));
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b.score", 32'(if_b.score_bcd), 32'(eb.s));
      chk("b.best",  32'(if_b.best_bcd),  32'(eb.b));
      chk("b.ovf",   32'(if_b.ovf),       32'(eb.o));
      chk("b.hex",   32'(if_b.hex),       32'(eb.h));
    end
  end

  initial begin
    rst_n = 1'b1; st = 2'd0; dir = 1'b0; sb = 1'b0;
    #1 rst_n = 1'b0;
    #1 model_reset();
    push_exp();
    $display("phase 0: power-on reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    phase(2'd1, 1'b0, 1'b0, 40);          // ten ticks -> 0010
    phase(2'd1, 1'b0, 1'b1, 3);           // show best, hex follows one cycle later
    phase(2'd2, 1'b0, 1'b0, 1);
    phase(2'd1, 1'b0, 1'b0, 2);
    phase(2'd0, 1'b0, 1'b0, 10);
    phase(2'd1, 1'b0, 1'b0, 2);           // prescaler resumes: one tick total
    phase(2'd3, 1'b0, 1'b0, 5);
    phase(2'd2, 1'b0, 1'b0, 1);
    phase(2'd1, 1'b1, 1'b0, 8);           // underflow from zero
    phase(2'd2, 1'b0, 1'b1, 1);
    phase(2'd1, 1'b0, 1'b0, 4 * 10003);   // through the maximum
    phase(2'd1, 1'b0, 1'b1, 4);
    phase(2'd2, 1'b0, 1'b1, 2);
    rand_phases(30);
    phase(2'd2, 1'b0, 1'b0, 1);
    phase(2'd1, 1'b0, 1'b0, 4 * 42);      // score 0042
    pulse_reset(2'd1, 1'b0, 1'b0);
    phase(2'd1, 1'b0, 1'b0, 6);
    rand_phases(20);

    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, want 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
